// File: rtl/spi_transaction_ctrl.sv
// spi_transaction_ctrl
//   Sequences the SPI byte datapath into complete two-byte MFRC522 register
//   transactions: an address byte followed by a data byte. A write shifts the
//   latched data byte out; a read shifts 0x00 out and captures the MISO byte.
//   The block owns NSS framing, the SCK generator enable/reset and the
//   init/reset strobes of the MOSI and MISO byte engines.
//
//   Optional feature macro: SPI_CTRL_TIMEOUT_EN
//     defined   : each byte wait (SHA/SHD) aborts after TIMEOUT_CYC cycles and
//                 pulses err.
//     undefined : byte waits are unbounded and err is tied low.
//
// Parameters
//   GUARD_CYC    NSS setup/hold guard in clk cycles (min 1)
//   TIMEOUT_CYC  per-byte wait limit in clk cycles (timeout build only)
//
// Ports (user side)
//   clk, rst            clock, synchronous active-high reset
//   start, rw           transaction request (sampled in IDLE), 1=read 0=write
//   reg_addr, wr_data   MFRC522 register index and write data
//   busy, done, err     status; done/err are single-cycle pulses
//   rd_data             last successfully read byte
// Ports (datapath side)
//   work, rstSCK        SCK generator enable / reset
//   initRd, initWr      start MISO capture / MOSI shift
//   rstRd, rstWr        clear MISO / MOSI byte engine
//   A                   MOSI source select: 00 address, 01 0x00, 10 dataWr, 11 hold
//   activeNSS           1 = NSS high (deselected)
//   address, dataWr     latched address byte {rw, reg_addr, 0} and data byte
//   doneRd, doneWr      byte-complete levels from the engines
//   dataRd              captured MISO byte
module spi_transaction_ctrl #(
  parameter int unsigned GUARD_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [5:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rd_data,
  output logic       work,
  output logic       rstSCK,
  output logic       initRd,
  output logic       initWr,
  output logic       rstRd,
  output logic       rstWr,
  output logic [1:0] A,
  output logic       activeNSS,
  output logic [7:0] address,
  output logic [7:0] dataWr,
  input  logic       doneRd,
  input  logic       doneWr,
  input  logic [7:0] dataRd
);

  localparam int unsigned MAX_CYC = (GUARD_CYC > TIMEOUT_CYC) ? GUARD_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
`ifdef SPI_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
`endif

  localparam logic [1:0] A_ADDR = 2'b00;
  localparam logic [1:0] A_ZERO = 2'b01;
  localparam logic [1:0] A_DATA = 2'b10;
  localparam logic [1:0] A_HOLD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    LDA,
    SHA,
    LDD,
    SHD,
    DESEL,
    FIN
  } stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] nssHighCnt;
  logic             nssHighOk;
  logic             isRead;

  logic       busyNext, doneNext, workNext, rstSckNext;
  logic       initRdNext, initWrNext, rstRdNext, rstWrNext, activeNssNext;
  logic [1:0] aNext;
  logic [7:0] rdDataNext, addressNext, dataWrNext;
`ifdef SPI_CTRL_TIMEOUT_EN
  logic       errNext;
  logic       abort;
`endif

  // The transaction direction lives in the MSB of the latched address byte.
  assign isRead = address[7];

  // NSS high-time tracker: saturates once NSS has been high long enough that
  // dropping it at the next edge still honours the guard between frames.
  assign nssHighOk = (nssHighCnt == GUARD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      nssHighCnt <= GUARD_LAST;
    end else if (!activeNSS) begin
      nssHighCnt <= '0;
    end else if (!nssHighOk) begin
      nssHighCnt <= nssHighCnt + CNT_W'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_data   <= '0;
      work      <= 1'b0;
      rstSCK    <= 1'b1;
      initRd    <= 1'b0;
      initWr    <= 1'b0;
      rstRd     <= 1'b1;
      rstWr     <= 1'b1;
      A         <= A_HOLD;
      activeNSS <= 1'b1;
      address   <= '0;
      dataWr    <= '0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      busy      <= busyNext;
      done      <= doneNext;
      rd_data   <= rdDataNext;
      work      <= workNext;
      rstSCK    <= rstSckNext;
      initRd    <= initRdNext;
      initWr    <= initWrNext;
      rstRd     <= rstRdNext;
      rstWr     <= rstWrNext;
      A         <= aNext;
      activeNSS <= activeNssNext;
      address   <= addressNext;
      dataWr    <= dataWrNext;
    end
  end

`ifdef SPI_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= errNext;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Next state and next output values; outputs hold unless a transition
  // changes them, done/err are pulses.
  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    busyNext      = busy;
    doneNext      = 1'b0;
    rdDataNext    = rd_data;
    workNext      = work;
    rstSckNext    = rstSCK;
    initRdNext    = initRd;
    initWrNext    = initWr;
    rstRdNext     = rstRd;
    rstWrNext     = rstWr;
    aNext         = A;
    activeNssNext = activeNSS;
    addressNext   = address;
    dataWrNext    = dataWr;
`ifdef SPI_CTRL_TIMEOUT_EN
    errNext       = 1'b0;
    abort         = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          stateNext     = SEL;
          cntNext       = '0;
          busyNext      = 1'b1;
          addressNext   = {rw, reg_addr, 1'b0};
          dataWrNext    = wr_data;
          workNext      = 1'b1;
          rstSckNext    = 1'b0;
          rstRdNext     = 1'b0;
          rstWrNext     = 1'b0;
          // Back-to-back frames keep NSS high until the guard has elapsed.
          activeNssNext = !nssHighOk;
        end
      end

      SEL: begin
        // Guard cycles are counted only once NSS is actually low.
        if (activeNSS) begin
          if (nssHighOk) begin
            activeNssNext = 1'b0;
          end
        end else if (cnt == GUARD_LAST) begin
          stateNext = LDA;
          cntNext   = '0;
          aNext     = A_ADDR;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end

      LDA: begin
        // Datapath sampled A on the negedge of this cycle.
        stateNext  = SHA;
        cntNext    = '0;
        aNext      = A_HOLD;
        initWrNext = 1'b1;
      end

      SHA: begin
        if (doneWr) begin
          stateNext  = LDD;
          cntNext    = '0;
          initWrNext = 1'b0;
          rstWrNext  = 1'b1;
          aNext      = isRead ? A_ZERO : A_DATA;
`ifdef SPI_CTRL_TIMEOUT_EN
        end else if (cnt == TIMEOUT_LAST) begin
          abort = 1'b1;
        end else begin
          cntNext = cnt + CNT_W'(1);
`endif
        end
      end

      LDD: begin
        stateNext  = SHD;
        cntNext    = '0;
        aNext      = A_HOLD;
        initWrNext = 1'b1;
        initRdNext = isRead;
        rstWrNext  = 1'b0;
      end

      SHD: begin
        if (doneWr && (!isRead || doneRd)) begin
          stateNext  = DESEL;
          cntNext    = '0;
          if (isRead) begin
            rdDataNext = dataRd;
          end
          initWrNext = 1'b0;
          initRdNext = 1'b0;
          rstWrNext  = 1'b1;
          rstRdNext  = 1'b1;
          workNext   = 1'b0;
          rstSckNext = 1'b1;
          aNext      = A_HOLD;
`ifdef SPI_CTRL_TIMEOUT_EN
        end else if (cnt == TIMEOUT_LAST) begin
          abort = 1'b1;
        end else begin
          cntNext = cnt + CNT_W'(1);
`endif
        end
      end

      DESEL: begin
        // NSS stays low for the hold guard; engines remain cleared.
        if (cnt == GUARD_LAST) begin
          stateNext     = FIN;
          cntNext       = '0;
          activeNssNext = 1'b1;
          doneNext      = 1'b1;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end

      FIN: begin
        stateNext = IDLE;
        cntNext   = '0;
        busyNext  = 1'b0;
      end

      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase

`ifdef SPI_CTRL_TIMEOUT_EN
    // Byte wait expired: release the bus immediately and report through err.
    if (abort) begin
      stateNext     = FIN;
      cntNext       = '0;
      initWrNext    = 1'b0;
      initRdNext    = 1'b0;
      rstWrNext     = 1'b1;
      rstRdNext     = 1'b1;
      rstSckNext    = 1'b1;
      workNext      = 1'b0;
      aNext         = A_HOLD;
      activeNssNext = 1'b1;
      errNext       = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_spi_transaction_ctrl.sv
// Directed bench for spi_transaction_ctrl with a behavioural model of the
// MOSI/MISO byte engines. Build with or without SPI_CTRL_TIMEOUT_EN.
module tb_spi_transaction_ctrl;

  localparam int unsigned GUARD = 4;
  localparam int unsigned TMO   = 64;

  logic       clk = 1'b0;
  logic       rst, start, rw;
  logic [5:0] reg_addr;
  logic [7:0] wr_data;
  logic       busy, done, err;
  logic [7:0] rd_data;
  logic       work, rstSCK, initRd, initWr, rstRd, rstWr;
  logic [1:0] A;
  logic       activeNSS;
  logic [7:0] address, dataWr;
  logic       doneRd = 1'b0;
  logic       doneWr = 1'b0;
  logic [7:0] dataRd = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_transaction_ctrl #(.GUARD_CYC(GUARD), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .reg_addr(reg_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err), .rd_data(rd_data),
    .work(work), .rstSCK(rstSCK), .initRd(initRd), .initWr(initWr),
    .rstRd(rstRd), .rstWr(rstWr), .A(A), .activeNSS(activeNSS),
    .address(address), .dataWr(dataWr), .doneRd(doneRd), .doneWr(doneWr),
    .dataRd(dataRd)
  );

  // Byte engine model: the MOSI source is picked from A on the negedge, the
  // shifted byte is logged when a shift starts, done rises after 8 (MOSI) or
  // 10 (MISO) cycles and stays high until the engine is reset.
  logic [7:0] loadByte = 8'h00;
  logic [7:0] misoByte = 8'h00;
  logic       stallWr  = 1'b0;
  logic       wrStarted = 1'b0;
  int         wrCnt = 0;
  int         rdCnt = 0;
  logic [7:0] mosiLog[$];
  int         doneCount = 0;
  int         errCount  = 0;
  int         nssViol   = 0;

  always @(negedge clk) begin
    case (A)
      2'b00:   loadByte = address;
      2'b01:   loadByte = 8'h00;
      2'b10:   loadByte = dataWr;
      default: loadByte = loadByte;
    endcase
  end

  always @(posedge clk) begin
    if (rstWr === 1'b1) begin
      wrCnt     <= 0;
      doneWr    <= 1'b0;
      wrStarted <= 1'b0;
    end else if (initWr === 1'b1 && !doneWr) begin
      if (!wrStarted) mosiLog.push_back(loadByte);
      wrStarted <= 1'b1;
      if (!stallWr) begin
        if (wrCnt == 7) doneWr <= 1'b1;
        wrCnt <= wrCnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rstRd === 1'b1) begin
      rdCnt  <= 0;
      doneRd <= 1'b0;
    end else if (initRd === 1'b1 && !doneRd) begin
      if (rdCnt == 9) begin
        doneRd <= 1'b1;
        dataRd <= misoByte;
      end
      rdCnt <= rdCnt + 1;
    end
  end

  // Pulse counters and NSS framing monitor.
  always @(posedge clk) begin
    if (done === 1'b1) doneCount <= doneCount + 1;
    if (err === 1'b1) errCount <= errCount + 1;
    if ((initWr === 1'b1 || initRd === 1'b1) && activeNSS !== 1'b0) nssViol <= nssViol + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mosiAt(input int idx);
    if (idx < mosiLog.size()) return 32'(mosiLog[idx]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic waitDone(input int maxCyc, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < maxCyc && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic waitInitWr(input int maxCyc, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < maxCyc && !seen; i++) begin
      if (initWr === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  initial begin
    logic seen;
    int   base;
    int   expDone;
    int   expErr;
    int   hi;
    int   k;

    rst = 1'b1; start = 1'b0; rw = 1'b0; reg_addr = '0; wr_data = '0;
    expDone = 0; expErr = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_done",      32'(done), 32'd0);
    chk("rst_err",       32'(err), 32'd0);
    chk("rst_nss",       32'(activeNSS), 32'd1);
    chk("rst_work",      32'(work), 32'd0);
    chk("rst_rstSCK",    32'(rstSCK), 32'd1);
    chk("rst_rstWrRd",   32'({rstWr, rstRd}), 32'h3);
    chk("rst_initWrRd",  32'({initWr, initRd}), 32'h0);
    chk("rst_A",         32'(A), 32'h3);
    chk("rst_rd_data",   32'(rd_data), 32'h00);
    rst = 1'b0;
    @(negedge clk);

    // Write reg 0x01 <- 0x0F, with an extra start while busy
    base = mosiLog.size();
    rw = 1'b0; reg_addr = 6'h01; wr_data = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wr_busy",    32'(busy), 32'd1);
    chk("wr_address", 32'(address), 32'h02);
    chk("wr_dataWr",  32'(dataWr), 32'h0F);
    chk("wr_nss_low", 32'(activeNSS), 32'd0);
    repeat (3) @(negedge clk);
    rw = 1'b1; reg_addr = 6'h3F; wr_data = 8'hEE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_address", 32'(address), 32'h02);
    chk("ign_dataWr",  32'(dataWr), 32'h0F);
    waitDone(300, seen);
    chk("wr_done_seen", 32'(seen), 32'd1);
    chk("wr_done_busy", 32'(busy), 32'd1);
    chk("wr_done_err",  32'(err), 32'd0);
    chk("wr_done_nss",  32'(activeNSS), 32'd1);
    chk("wr_rd_data",   32'(rd_data), 32'h00);
    chk("wr_mosi_n",    32'(mosiLog.size() - base), 32'd2);
    chk("wr_mosi_0",    mosiAt(base), 32'h02);
    chk("wr_mosi_1",    mosiAt(base + 1), 32'h0F);
    @(negedge clk);
    chk("wr_busy_drop", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    expDone = 1;
    chk("ign_one_done", 32'(doneCount), 32'(expDone));
    chk("wr_busy_idle", 32'(busy), 32'd0);

    // Read reg 0x37, MISO returns 0x92
    base = mosiLog.size();
    misoByte = 8'h92;
    rw = 1'b1; reg_addr = 6'h37; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rd_address", 32'(address), 32'hEE);
    waitDone(300, seen);
    chk("rd_done_seen", 32'(seen), 32'd1);
    chk("rd_rd_data",   32'(rd_data), 32'h92);
    chk("rd_err",       32'(err), 32'd0);
    chk("rd_mosi_n",    32'(mosiLog.size() - base), 32'd2);
    chk("rd_mosi_0",    mosiAt(base), 32'hEE);
    chk("rd_mosi_1",    mosiAt(base + 1), 32'h00);
    repeat (3) @(negedge clk);
    expDone = 2;
    chk("rd_done_cnt", 32'(doneCount), 32'(expDone));

    // Stalled MOSI engine on a write of reg 0x10 <- 0x55
    base = mosiLog.size();
    stallWr = 1'b1;
    rw = 1'b0; reg_addr = 6'h10; wr_data = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitInitWr(50, seen);
    chk("stall_sha_entry", 32'(seen), 32'd1);
`ifdef SPI_CTRL_TIMEOUT_EN
    k = 0;
    seen = 1'b0;
    while (k < 200 && !seen) begin
      @(negedge clk);
      k++;
      if (err === 1'b1) seen = 1'b1;
    end
    chk("tmo_latency",  32'(k), 32'(TMO));
    chk("tmo_nss",      32'(activeNSS), 32'd1);
    chk("tmo_done",     32'(done), 32'd0);
    chk("tmo_busy",     32'(busy), 32'd1);
    chk("tmo_work",     32'(work), 32'd0);
    chk("tmo_initWr",   32'(initWr), 32'd0);
    chk("tmo_rd_data",  32'(rd_data), 32'h92);
    @(negedge clk);
    chk("tmo_busy_drop", 32'(busy), 32'd0);
    stallWr = 1'b0;
    repeat (5) @(negedge clk);
    expErr = 1;
`else
    repeat (100) @(negedge clk);
    chk("stall_busy",   32'(busy), 32'd1);
    chk("stall_initWr", 32'(initWr), 32'd1);
    chk("stall_nss",    32'(activeNSS), 32'd0);
    chk("stall_err",    32'(err), 32'd0);
    stallWr = 1'b0;
    waitDone(300, seen);
    chk("stall_done_seen", 32'(seen), 32'd1);
    chk("stall_rd_data",   32'(rd_data), 32'h92);
    chk("stall_mosi_0",    mosiAt(base), 32'h20);
    chk("stall_mosi_1",    mosiAt(base + 1), 32'h55);
    repeat (3) @(negedge clk);
    expDone = expDone + 1;
`endif
    chk("stall_err_cnt",  32'(errCount), 32'(expErr));
    chk("stall_done_cnt", 32'(doneCount), 32'(expDone));

    // Reset while shifting the data byte of a read
    base = mosiLog.size();
    misoByte = 8'h5A;
    rw = 1'b1; reg_addr = 6'h37; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (mosiLog.size() >= base + 2) seen = 1'b1;
    end
    chk("rstmid_in_shd", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_nss",     32'(activeNSS), 32'd1);
    chk("rstmid_work",    32'(work), 32'd0);
    chk("rstmid_rstSCK",  32'(rstSCK), 32'd1);
    chk("rstmid_busy",    32'(busy), 32'd0);
    chk("rstmid_done",    32'(done), 32'd0);
    chk("rstmid_err",     32'(err), 32'd0);
    chk("rstmid_rd_data", 32'(rd_data), 32'h00);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rstmid_done_cnt", 32'(doneCount), 32'(expDone));
    chk("rstmid_err_cnt",  32'(errCount), 32'(expErr));
    chk("rstmid_idle",     32'(busy), 32'd0);

    // Back-to-back writes with start held high: reg 0x05 <- 0xA5
    base = mosiLog.size();
    rw = 1'b0; reg_addr = 6'h05; wr_data = 8'hA5; start = 1'b1;
    waitDone(300, seen);
    chk("b2b_first_done", 32'(seen), 32'd1);
    hi = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (activeNSS === 1'b1) hi++;
      else break;
    end
    chk("b2b_nss_gap", 32'(hi >= int'(GUARD)), 32'd1);
    start = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    waitDone(300, seen);
    chk("b2b_second_done", 32'(seen), 32'd1);
    repeat (5) @(negedge clk);
    expDone = expDone + 2;
    chk("b2b_done_cnt", 32'(doneCount), 32'(expDone));
    chk("b2b_mosi_n",   32'(mosiLog.size() - base), 32'd4);
    chk("b2b_mosi_0",   mosiAt(base), 32'h0A);
    chk("b2b_mosi_1",   mosiAt(base + 1), 32'hA5);
    chk("b2b_mosi_2",   mosiAt(base + 2), 32'h0A);
    chk("b2b_mosi_3",   mosiAt(base + 3), 32'hA5);
    chk("b2b_idle",     32'(busy), 32'd0);

    chk("nss_framing", 32'(nssViol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
